// File: rtl/snes_pad_reader.sv
// SNES-style serial gamepad front end.
// Periodically latches the pad and clocks out 16 active-low bits. The frame is
// inverted so that 1 = pressed, then debounced across polls before it drives
// the per-key levels used by the joypad register block.
module snes_pad_reader #(
  parameter int CLK_DIV     = 200,      // fclk cycles per pad_clk half-period
  parameter int POLL_CYCLES = 1100000,  // fclk cycles between poll starts
  parameter int DEBOUNCE    = 2         // identical polls needed to update Keys
) (
  input  logic        fclk,
  input  logic        rst,
  output logic        pad_latch,
  output logic        pad_clk,
  input  logic        pad_data,
  output logic        KeyA,
  output logic        KeyB,
  output logic        KeySelect,
  output logic        KeyStart,
  output logic        KeyRight,
  output logic        KeyLeft,
  output logic        KeyUp,
  output logic        KeyDown,
  output logic        KeyR,
  output logic        KeyL,
  output logic        KeyX,
  output logic        KeyY,
  output logic [15:0] frame_raw,
  output logic        poll_done
);

  localparam int PW  = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int PHW = $clog2(2 * CLK_DIV);
  localparam int DW  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;

  localparam logic [PW-1:0]  POLL_LAST  = PW'(POLL_CYCLES - 1);
  localparam logic [PHW-1:0] LATCH_LAST = PHW'(2 * CLK_DIV - 1);
  localparam logic [PHW-1:0] HALF_LAST  = PHW'(CLK_DIV - 1);
  localparam logic [DW-1:0]  DB_MAX     = DW'(DEBOUNCE);

  typedef enum logic [2:0] {IDLE, LATCH, FIRST, LOW, HIGH, DONE} state_t;

  state_t         state, state_next;
  logic [PW-1:0]  poll_cnt;
  logic [PHW-1:0] phase, phase_next;
  logic [3:0]     bit_idx, bit_next;
  logic           poll_start;
  logic           sample;     // capture pad_data into the shift register
  logic           frame_end;  // 16th bit is on pad_data this cycle

  logic [14:0]    sr;
  logic [15:0]    frame_new;
  logic [11:0]    cand, cand_next, keys;
  logic [DW-1:0]  db_cnt, db_cnt_next;

  assign poll_start = (poll_cnt == POLL_LAST);

  // Next-state logic: each state lasts a whole number of CLK_DIV units.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_next = state;
    phase_next = phase + PHW'(1);
    bit_next   = bit_idx;
    sample     = 1'b0;
    frame_end  = 1'b0;
    case (state)
      IDLE: begin
        phase_next = '0;
        bit_next   = 4'd0;
        if (poll_start) state_next = LATCH;
      end
      LATCH: begin
        if (phase == LATCH_LAST) begin
          state_next = FIRST;
          phase_next = '0;
        end
      end
      FIRST: begin
        if (phase == HALF_LAST) begin
          sample     = 1'b1;
          bit_next   = 4'd1;
          state_next = LOW;
          phase_next = '0;
        end
      end
      LOW: begin
        if (phase == HALF_LAST) begin
          state_next = HIGH;
          phase_next = '0;
        end
      end
      HIGH: begin
        if (phase == HALF_LAST) begin
          phase_next = '0;
          if (bit_idx == 4'd15) begin
            frame_end  = 1'b1;
            state_next = DONE;
          end else begin
            sample     = 1'b1;
            bit_next   = bit_idx + 4'd1;
            state_next = LOW;
          end
        end
      end
      DONE: begin
        phase_next = '0;
        state_next = IDLE;
      end
      default: begin
        phase_next = '0;
        state_next = IDLE;
      end
    endcase
  end

  // Debounce decision on the 12 key bits of the frame completing this cycle.
  always_comb begin
    frame_new = {pad_data, sr};
    if (~frame_new[11:0] == cand) begin
      cand_next   = cand;
      db_cnt_next = (db_cnt >= DB_MAX) ? DB_MAX : db_cnt + DW'(1);
    end else begin
      cand_next   = ~frame_new[11:0];
      db_cnt_next = DW'(1);
    end
  end

  // Sequencer registers; pad strobes are registered from the next state so
  // they are glitch-free and aligned with the state they belong to.
  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      phase     <= '0;
      bit_idx   <= 4'd0;
      poll_cnt  <= POLL_LAST;  // first poll starts on the first edge after reset
      pad_latch <= 1'b0;
      pad_clk   <= 1'b1;
      poll_done <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state     <= state_next;
      phase     <= phase_next;
      bit_idx   <= bit_next;
      poll_cnt  <= poll_start ? '0 : poll_cnt + PW'(1);
      pad_latch <= (state_next == LATCH);
      pad_clk   <= (state_next != LOW);
      poll_done <= (state_next == DONE);
    end
  end

  // Frame capture and debounced key levels; all published on the edge into DONE.
  // pad_data only moves in response to our own fclk-generated strobes and has
  // a full half-period to settle, so it is sampled directly.
  always_ff @(posedge fclk or posedge rst) begin
    if (rst) begin
      sr        <= '0;
      frame_raw <= '0;
      cand      <= '0;
      db_cnt    <= '0;
      keys      <= '0;
    end else begin
      if (sample) sr[bit_idx] <= pad_data;
      if (frame_end) begin
        frame_raw <= ~frame_new;
        cand      <= cand_next;
        db_cnt    <= db_cnt_next;
        if (db_cnt_next >= DB_MAX) keys <= cand_next;
      end
    end
  end

  // Serial index to key mapping.
  assign KeyB      = keys[0];
  assign KeyY      = keys[1];
  assign KeySelect = keys[2];
  assign KeyStart  = keys[3];
  assign KeyUp     = keys[4];
  assign KeyDown   = keys[5];
  assign KeyLeft   = keys[6];
  assign KeyRight  = keys[7];
  assign KeyA      = keys[8];
  assign KeyX      = keys[9];
  assign KeyL      = keys[10];
  assign KeyR      = keys[11];

endmodule

// File: tb/tb_snes_pad_reader.sv
// Bench for snes_pad_reader: a cycle-position model of the poll waveform and
// debounce rule, plus literal expectations for the key scenarios.
module tb_snes_pad_reader;

  localparam int CLK_DIV = 4;
  localparam int POLL    = 200;
  localparam int DEB     = 2;
  localparam int DONE_AT = 33 * CLK_DIV;  // poll_done position within a poll

  logic fclk = 1'b0;
  logic rst  = 1'b1;
  always #5 fclk = ~fclk;

  // ---------------- DUT A (DEBOUNCE = 2) ----------------
  logic        pad_latch, pad_clk, pad_data, poll_done;
  logic        KeyA, KeyB, KeySelect, KeyStart, KeyRight, KeyLeft, KeyUp, KeyDown;
  logic        KeyR, KeyL, KeyX, KeyY;
  logic [15:0] frame_raw;
  logic [11:0] keys_a;

  snes_pad_reader #(.CLK_DIV(CLK_DIV), .POLL_CYCLES(POLL), .DEBOUNCE(DEB)) dut_a (
    .fclk(fclk), .rst(rst), .pad_latch(pad_latch), .pad_clk(pad_clk),
    .pad_data(pad_data), .KeyA(KeyA), .KeyB(KeyB), .KeySelect(KeySelect),
    .KeyStart(KeyStart), .KeyRight(KeyRight), .KeyLeft(KeyLeft), .KeyUp(KeyUp),
    .KeyDown(KeyDown), .KeyR(KeyR), .KeyL(KeyL), .KeyX(KeyX), .KeyY(KeyY),
    .frame_raw(frame_raw), .poll_done(poll_done)
  );

  assign keys_a = {KeyR, KeyL, KeyX, KeyA, KeyRight, KeyLeft, KeyDown, KeyUp,
                   KeyStart, KeySelect, KeyY, KeyB};

  // ---------------- DUT B (DEBOUNCE = 1) ----------------
  logic        pad_latch_b, pad_clk_b, pad_data_b, poll_done_b;
  logic        KeyA_b, KeyB_b, KeySelect_b, KeyStart_b, KeyRight_b, KeyLeft_b;
  logic        KeyUp_b, KeyDown_b, KeyR_b, KeyL_b, KeyX_b, KeyY_b;
  logic [15:0] frame_raw_b;
  logic [11:0] keys_b;

  snes_pad_reader #(.CLK_DIV(CLK_DIV), .POLL_CYCLES(POLL), .DEBOUNCE(1)) dut_b (
    .fclk(fclk), .rst(rst), .pad_latch(pad_latch_b), .pad_clk(pad_clk_b),
    .pad_data(pad_data_b), .KeyA(KeyA_b), .KeyB(KeyB_b), .KeySelect(KeySelect_b),
    .KeyStart(KeyStart_b), .KeyRight(KeyRight_b), .KeyLeft(KeyLeft_b),
    .KeyUp(KeyUp_b), .KeyDown(KeyDown_b), .KeyR(KeyR_b), .KeyL(KeyL_b),
    .KeyX(KeyX_b), .KeyY(KeyY_b), .frame_raw(frame_raw_b), .poll_done(poll_done_b)
  );

  assign keys_b = {KeyR_b, KeyL_b, KeyX_b, KeyA_b, KeyRight_b, KeyLeft_b, KeyDown_b,
                   KeyUp_b, KeyStart_b, KeySelect_b, KeyY_b, KeyB_b};

  // ---------------- pad models (4021-style shift register) ----------------
  logic [15:0] pressed      = 16'h0000;  // 1 = pressed, bit i = serial bit i
  logic        disconnected = 1'b0;
  logic [15:0] pad_sr       = 16'hFFFF;
  logic [15:0] pad_sr_b     = 16'hFFFF;

  always @(posedge pad_latch) pad_sr = ~pressed;
  always @(posedge pad_clk)   pad_sr = {1'b1, pad_sr[15:1]};
  assign pad_data = disconnected ? 1'b1 : pad_sr[0];

  always @(posedge pad_latch_b) pad_sr_b = ~16'h0C10;  // Up + L + R
  always @(posedge pad_clk_b)   pad_sr_b = {1'b1, pad_sr_b[15:1]};
  assign pad_data_b = pad_sr_b[0];

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycles since the first edge after reset release (-1 = not yet started).
  int t_cnt = -1;
  always @(posedge fclk or posedge rst) begin
    if (rst) t_cnt = -1;
    else     t_cnt = t_cnt + 1;
  end

  // Model state for DUT A.
  logic [15:0] frame_m, frame_exp;
  logic [11:0] cand_m, keys_m;
  int          cnt_m;
  int          p;
  logic        exp_latch, exp_clk, exp_done;

  initial begin
    frame_m = '0; frame_exp = '0; cand_m = '0; keys_m = '0; cnt_m = 0;
  end

  // Every cycle: derive expected outputs from the position within the poll.
  always @(negedge fclk) begin
    if (rst) begin
      frame_exp = '0; cand_m = '0; keys_m = '0; cnt_m = 0;
      p = POLL - 1;
    end else if (t_cnt < 0) begin
      p = POLL - 1;
    end else begin
      p = t_cnt % POLL;
    end
    if (!rst && t_cnt >= 0 && p == 0) frame_m = disconnected ? 16'h0000 : pressed;
    if (!rst && t_cnt >= 0 && p == DONE_AT) begin
      frame_exp = frame_m;
      if (frame_m[11:0] == cand_m) begin
        cnt_m = (cnt_m + 1 > DEB) ? DEB : cnt_m + 1;
      end else begin
        cand_m = frame_m[11:0];
        cnt_m  = 1;
      end
      if (cnt_m >= DEB) keys_m = cand_m;
    end
    exp_latch = (p < 2 * CLK_DIV);
    exp_clk   = !(p >= 3 * CLK_DIV && p < DONE_AT && ((p - 3 * CLK_DIV) % (2 * CLK_DIV)) < CLK_DIV);
    exp_done  = (p == DONE_AT);
    check("pad_latch", pad_latch, exp_latch);
    check("pad_clk",   pad_clk,   exp_clk);
    check("poll_done", poll_done, exp_done);
    check("frame_raw", frame_raw, frame_exp);
    check("keys",      keys_a,    keys_m);
  end

  // Wait (bounded) for the next poll_done; cyc = negedges elapsed.
  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge fclk);
      cyc++;
    end while (!poll_done && cyc < 2 * POLL);
    check("poll_done_seen", poll_done, 1'b1);
  endtask

  int cyc;
  int lat_cnt;
  int guard;

  initial begin
    pressed = 16'h0100;  // A pressed
    rst = 1'b1;
    repeat (3) @(negedge fclk);
    check("rst_latch", pad_latch, 1'b0);
    check("rst_clk",   pad_clk,   1'b1);
    check("rst_frame", frame_raw, 16'h0000);
    check("rst_keys",  keys_a,    12'h000);
    rst = 1'b0;

    // Poll 1: latch width and done latency measured from release.
    cyc = 0; lat_cnt = 0;
    do begin
      @(negedge fclk);
      cyc++;
      if (pad_latch) lat_cnt++;
    end while (!poll_done && cyc < 2 * POLL);
    check("latch_width",      lat_cnt, 8);
    check("done_after_latch", cyc - 1, 132);
    check("p1_frame",         frame_raw, 16'h0100);
    check("p1_keyA",          KeyA, 1'b0);
    check("b_frame",          frame_raw_b, 16'h0C10);
    check("b_keys",           keys_b, 12'hC10);
    check("b_keyUp",          KeyUp_b, 1'b1);

    // Poll 2: A confirmed.
    wait_done(cyc);
    check("p2_period", cyc, 200);
    check("p2_keyA",   KeyA, 1'b1);
    check("p2_keys",   keys_a, 12'h100);

    // Polls 3..6: B toggles every poll, so it never settles.
    for (int k = 0; k < 4; k++) begin
      pressed = (k % 2 == 0) ? 16'h0001 : 16'h0000;
      wait_done(cyc);
      check("alt_period", cyc, 200);
      check("alt_frame",  frame_raw, (k % 2 == 0) ? 16'h0001 : 16'h0000);
      check("alt_keyB",   KeyB, 1'b0);
      check("alt_keyA",   KeyA, 1'b1);
    end

    // Poll 7: abort during the 5th LOW phase.
    pressed = 16'h0100;
    guard = 0;
    do begin
      @(negedge fclk);
      guard++;
    end while (t_cnt % POLL != 3 * CLK_DIV + 8 * CLK_DIV + 1 && guard < 2 * POLL);
    check("abort_in_low", pad_clk, 1'b0);
    check("abort_keyA_before", KeyA, 1'b1);
    #2 rst = 1'b1;
    disconnected = 1'b1;
    #1;
    check("abort_clk",   pad_clk,   1'b1);
    check("abort_latch", pad_latch, 1'b0);
    check("abort_done",  poll_done, 1'b0);
    check("abort_frame", frame_raw, 16'h0000);
    check("abort_keys",  keys_a,    12'h000);
    repeat (2) @(negedge fclk);
    rst = 1'b0;

    // Disconnected pad: fresh latch next cycle, no leftover poll_done.
    @(negedge fclk);
    check("relatch", pad_latch, 1'b1);
    wait_done(cyc);
    check("disc_first_done", cyc, 132);
    check("disc_frame", frame_raw, 16'h0000);
    check("disc_keys",  keys_a, 12'h000);
    for (int k = 0; k < 2; k++) begin
      wait_done(cyc);
      check("disc_period", cyc, 200);
      check("disc_frame",  frame_raw, 16'h0000);
      check("disc_keys",   keys_a, 12'h000);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
